// File: rtl/instr_encoder.sv
// RV32 instruction encoder with a small output FIFO and issue/error counters.
// Optional immediate/format range checking is enabled by ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] cnt_issued,
    output logic [15:0] cnt_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic [31:0] enc_instr;
    logic        enc_err;

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic [15:0]   iss_q, iss_d;
    logic [15:0]   errc_q, errc_d;
    logic [32:0]   wdata_d;
    logic [32:0]   head;
    logic          push, pop;

    always_comb begin
        enc_instr = NOP;
        unique case (in_fmt)
            3'd0: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
            3'd1: enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3,
                               in_rd, OP_IMM};
            3'd2: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            3'd3: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:0], OP_STORE};
            3'd4: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:0], OP_BRANCH};
            3'd5: enc_instr = {in_imm[31:12], in_rd, OP_LUI};
            3'd6: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11],
                               in_imm[19:12], in_rd, OP_JAL};
            default: enc_instr = NOP;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic sx11, sx20;

    always_comb begin
        sx11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        sx20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
        enc_err = 1'b0;
        unique case (in_fmt)
            3'd0, 3'd2, 3'd3, 3'd4: enc_err = ~sx11;
            3'd1: enc_err = (|in_imm[31:5])
                          | ~((in_funct3 == 3'd1) | (in_funct3 == 3'd5))
                          | ~((in_funct7 == 7'h00) | (in_funct7 == 7'h20));
            3'd5: enc_err = |in_imm[11:0];
            3'd6: enc_err = in_imm[0] | ~sx20;
            default: enc_err = 1'b1;
        endcase
    end
`else
    assign enc_err = 1'b0;
`endif

    assign in_ready  = rdy_q && (cnt_q < FULL);
    assign out_valid = (cnt_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign out_instr = out_valid ? head[31:0] : '0;
    assign out_err   = out_valid & head[32];
    assign cnt_issued = iss_q;
    assign cnt_err    = errc_q;

    always_comb begin
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        wdata_d  = {enc_err, enc_instr};
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        iss_d  = (pop && iss_q != 16'hFFFF) ? iss_q + 16'd1 : iss_q;
        errc_d = (pop && head[32] && errc_q != 16'hFFFF) ? errc_q + 16'd1
                                                        : errc_q;
        // in_ready stays low through reset and rises on the first clock after
        rdy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            iss_q    <= '0;
            errc_q   <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= wdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            iss_q    <= iss_d;
            errc_q   <= errc_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + randomized scoreboard bench for instr_encoder.
// Expected error flags follow ENC_RANGE_CHECK_EN.
module tb_instr_encoder;

`ifdef ENC_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] cnt_issued, cnt_err;

    int total = 0;
    int bad = 0;
    logic [32:0] sb[$];
    logic [32:0] exp_w;
    int unsigned exp_iss = 0, exp_ec = 0;

    instr_encoder #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .cnt_issued(cnt_issued), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(
        input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] imm);
        logic [31:0] w;
        logic e, s11, s20;
        s11 = (imm == {{20{imm[11]}}, imm[11:0]});
        s20 = (imm == {{11{imm[20]}}, imm[20:0]});
        case (f)
            3'd0: begin w = {imm[11:0], rs1, f3, rd, 7'h13}; e = !s11; end
            3'd1: begin
                w = {f7, imm[4:0], rs1, f3, rd, 7'h13};
                e = (imm[31:5] != 0) || !(f3 == 1 || f3 == 5)
                    || !(f7 == 0 || f7 == 7'h20);
            end
            3'd2: begin w = {imm[11:0], rs1, f3, rd, 7'h03}; e = !s11; end
            3'd3: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23}; e = !s11;
            end
            3'd4: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h63}; e = !s11;
            end
            3'd5: begin w = {imm[31:12], rd, 7'h37}; e = (imm[11:0] != 0); end
            3'd6: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
                e = imm[0] || !s20;
            end
            default: begin w = 32'h13; e = 1'b1; end
        endcase
        return {e & CHK, w};
    endfunction

    task automatic drive(input logic [2:0] f, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm, input logic [32:0] e);
        in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        exp_w = e;
        in_valid = 1'b1;
    endtask

    task automatic tick(output bit acc);
        logic [32:0] w;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("sb_not_empty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk("out_instr", out_instr, w[31:0]);
                chk("out_err", 32'(out_err), 32'(w[32]));
                if (exp_iss != 16'hFFFF) exp_iss++;
                if (w[32] && exp_ec != 16'hFFFF) exp_ec++;
            end
        end
        if (acc) sb.push_back(exp_w);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit a;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++) tick(a);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("cnt_issued", 32'(cnt_issued), exp_iss);
        chk("cnt_err", 32'(cnt_err), exp_ec);
    endtask

    initial begin
        bit acc;
        logic [32:0] ea, eb, ec;
        logic [31:0] r, imm;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_cnt_issued", 32'(cnt_issued), 32'd0);
        chk("rst_cnt_err", 32'(cnt_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("first_edge_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        drive(0, 1, 2, 0, 0, 0, 32'hFFFF_FFFF, {1'b0, 32'hFFF1_0093});
        tick(acc);
        chk("iarith_acc", 32'(acc), 32'd1);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        chk("lat1_instr", out_instr, 32'hFFF1_0093);
        in_valid = 1'b0;
        tick(acc);
        chk("cnt_issued_one", 32'(cnt_issued), 32'd1);

        drive(3, 0, 4, 3, 2, 0, 32'd8, {1'b0, 32'h0032_2423});
        tick(acc);
        drive(5, 5, 0, 0, 0, 0, 32'h1234_5000, {1'b0, 32'h1234_52B7});
        tick(acc);
        drive(6, 1, 0, 0, 0, 0, 32'h800, {1'b0, 32'h0010_00EF});
        tick(acc);
        drive(0, 0, 0, 0, 0, 0, 32'h800, {CHK, 32'h8000_0013});
        tick(acc);
        drive(7, 3, 3, 3, 3, 3, 32'h1234, {CHK, 32'h0000_0013});
        tick(acc);
        drain();
        chk("cnt_err_directed", 32'(cnt_err), CHK ? 32'd2 : 32'd0);

        out_ready = 1'b0;
        ea = model(2, 7, 8, 0, 3'd2, 0, 32'hFFFF_FFF0);
        eb = model(4, 0, 9, 10, 3'd1, 0, 32'h7FC);
        ec = model(1, 11, 12, 0, 3'd5, 7'h20, 32'd3);
        drive(2, 7, 8, 0, 3'd2, 0, 32'hFFFF_FFF0, ea);
        tick(acc);
        drive(4, 0, 9, 10, 3'd1, 0, 32'h7FC, eb);
        tick(acc);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(1, 11, 12, 0, 3'd5, 7'h20, 32'd3, ec);
        tick(acc);
        chk("third_held", 32'(acc), 32'd0);
        chk("hold_instr_a", out_instr, ea[31:0]);
        tick(acc);
        chk("hold_instr_b", out_instr, ea[31:0]);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) tick(acc);
        chk("third_accepted", 32'(acc), 32'd1);
        drain();

        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            imm = r[0] ? $urandom : {{20{r[11]}}, r[11:0]};
            r = $urandom;
            drive(r[2:0], r[7:3], r[12:8], r[17:13], r[20:18], r[27:21], imm,
                  model(r[2:0], r[7:3], r[12:8], r[17:13], r[20:18],
                        r[27:21], imm));
            in_valid = r[28] | r[29];
            out_ready = r[30] | r[31];
            tick(acc);
        end
        drain();

        out_ready = 1'b0;
        drive(5, 2, 0, 0, 0, 0, 32'hABCD_E000, {1'b0, 32'hABCD_E137});
        tick(acc);
        drive(6, 4, 0, 0, 0, 0, 32'h0000_0010, {1'b0, 32'h0100_026F});
        tick(acc);
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_instr", out_instr, 32'd0);
        chk("mid_rst_cnt_issued", 32'(cnt_issued), 32'd0);
        chk("mid_rst_cnt_err", 32'(cnt_err), 32'd0);
        sb.delete();
        exp_iss = 0;
        exp_ec = 0;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(acc);
            chk("no_stale_word", 32'(out_valid), 32'd0);
        end
        drive(6, 1, 0, 0, 0, 0, 32'h800, {1'b0, 32'h0010_00EF});
        tick(acc);
        drain();
        chk("post_rst_issued", 32'(cnt_issued), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  encoder can accept.
REQ-006 SHALL have port in_fmt  input  3  0=I-arith, 1=I-shift, 2=Load, 3=Store, 4=Branch, 5=U, 6=J, 7=illegal.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 SHALL have ports in_funct3  input  3 and in_funct7  input  7  function fields.
REQ-009 SHALL have port in_imm  input  32  immediate value.
REQ-010 SHALL have ports out_valid  output  1, out_ready  input  1, out_instr  output  32  encoded word.
REQ-011 SHALL have port out_err  output  1  immediate/format illegal for the word on out_instr.
REQ-012 SHALL have ports cnt_issued, cnt_err  output  16  counters.

Function
REQ-013 SHALL accept a request when in_valid && in_ready; in_ready = FIFO occupancy < DEPTH, from registered state only.
REQ-014 SHALL use opcodes I/I-shift 0010011, Load 0000011, Store 0100011, Branch 1100011, U 0110111, J 1101111; fmt 7 emits 0x00000013.
REQ-015 SHALL pack I-arith/Load as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-016 SHALL pack I-shift as {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-017 SHALL pack Store and Branch as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} (Branch uses the S layout decoded by imm_gen).
REQ-018 SHALL pack U as {imm[31:12], rd, opcode}.
REQ-019 SHALL pack J as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-020 SHALL present an accepted word on out_instr with out_valid=1 in the next cycle when the FIFO was empty (latency 1).
REQ-021 SHALL pop on out_valid && out_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-022 SHALL hold out_instr/out_err stable while out_valid && !out_ready, and emit words in acceptance order.
REQ-023 SHALL increment cnt_issued per pop and cnt_err per popped word with out_err=1; both saturate at 0xFFFF.

Reset
REQ-024 SHALL, while reset=0, clear FIFO pointers/occupancy and counters; out_valid=0, out_err=0, out_instr=0, in_ready=0.
REQ-025 SHALL drive in_ready=1 from the first rising edge after reset deasserts.
REQ-026 SHALL discard all FIFO contents on reset mid-operation; no partial word emitted afterwards.

Configuration
REQ-027 SHALL, with ENC_RANGE_CHECK_EN defined, set out_err=1 when: I-arith/Load/Store/Branch imm is not sign-extension of imm[11]; I-shift imm[31:5]!=0, funct3 not in {1,5}, or funct7 not in {0000000,0100000}; U imm[11:0]!=0; J imm[0]!=0 or imm not sign-extension of imm[20]; fmt=7; the word is still emitted with truncated fields.
REQ-028 SHALL, without ENC_RANGE_CHECK_EN, tie out_err=0, keep cnt_err at 0, and silently truncate fields.

Verification
REQ-029 SHALL cover: fmt=0, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, out_ready=1 -> next cycle out_instr=0xFFF10093, out_err=0, cnt_issued=1.
REQ-030 SHALL cover: fmt=3, rs1=4, rs2=3, funct3=2, imm=8 -> out_instr=0x00322423; fmt=5, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-031 SHALL cover: fmt=6, rd=1, imm=0x800 -> out_instr=0x001000EF, out_err=0.
REQ-032 SHALL cover: ENC_RANGE_CHECK_EN defined, fmt=0, imm=0x800 -> out_err=1, cnt_err=1; undefined -> out_err=0, cnt_err=0.
REQ-033 SHALL cover: out_ready=0, three back-to-back requests, DEPTH=2 -> in_ready=0 after second accept; third held until out_ready=1; outputs in order.
REQ-034 SHALL cover: reset=0 asserted with 2 words queued -> out_valid=0 asynchronously, counters 0, no stale word after release.
